// File: rtl/serial_subtractor_16_if.sv
// serial_subtractor_16_if: operand and result valid/ready handshakes of the serial subtractor.
interface serial_subtractor_16_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout);
    modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout);
endinterface

// File: rtl/serial_subtractor_16.sv
// serial_subtractor_16: bit-serial a - b - bin, one full-subtractor cell, LSB first.
module serial_subtractor_16 #(parameter int WIDTH = 16) (
    input logic                   clk,
    input logic                   rst,
    serial_subtractor_16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] ar, bsr, res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             ak, bk, d, br_next;
    assign ak = ar[0];
    assign bk = bsr[0];
    assign d = ak ^ bk ^ br;
    assign br_next = (~ak & bk) | (~(ak ^ bk) & br);
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ar       <= '0;
            bsr      <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ar    <= bus.a;
                    bsr   <= bus.b;
                    br    <= bus.bin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    res <= {d, res[WIDTH-1:1]};
                    ar  <= ar >> 1;
                    bsr <= bsr >> 1;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // diff is a separate register so it stays stable while the next operation shifts
                        bus.diff <= {d, res[WIDTH-1:1]};
                        bus.bout <= br_next;
                        cnt      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor_16.sv
// tb_serial_subtractor_16: directed vectors with hand-computed differences, latency and handshake checks.
module tb_serial_subtractor_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;
    serial_subtractor_16_if #(.WIDTH(16)) bus ();
    serial_subtractor_16 #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bin);
        check("rdy_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            tick;
            cycles++;
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ed, input logic eb);
        int c;
        accept(a, b, bin);
        bus.a = ~a;
        bus.b = ~b;
        bus.bin = ~bin;
        wait_done(c);
        check("latency", c, 16);
        check("diff", bus.diff, ed);
        check("bout", bus.bout, eb);
        tick;
        check("ov_drop", bus.out_valid, 0);
        check("rdy_back", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_rdy", bus.in_ready, 1);
        check("rst_ov", bus.out_valid, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        #11 rst = 1'b0;
        tick;
        run(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
        run(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1);
        run(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0);
        // in_valid held high with a changing a, then backpressure in DONE
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h0100;
        bus.b = 16'h0001;
        bus.bin = 1'b0;
        tick;
        for (int i = 0; i < 16; i++) begin
            check("rdy_run", bus.in_ready, 0);
            bus.a = 16'(i * 16'h0707);
            tick;
        end
        check("bp_ov", bus.out_valid, 1);
        check("bp_diff", bus.diff, 16'h00FF);
        check("bp_bout", bus.bout, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_ov", bus.out_valid, 1);
            check("hold_rdy", bus.in_ready, 0);
            check("hold_diff", bus.diff, 16'h00FF);
            check("hold_bout", bus.bout, 0);
        end
        bus.a = 16'h0010;
        bus.b = 16'h0001;
        bus.out_ready = 1'b1;
        tick;
        check("rel_rdy", bus.in_ready, 1);
        check("rel_ov", bus.out_valid, 0);
        tick;
        check("reacc_rdy", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        wait_done(n);
        check("b2b_lat", n, 16);
        check("b2b_diff", bus.diff, 16'h000F);
        check("b2b_bout", bus.bout, 0);
        tick;
        // asynchronous reset between the 8th and 9th RUN edges
        accept(16'h4000, 16'h0001, 1'b0);
        repeat (8) tick;
        #2 rst = 1'b1;
        #1;
        check("mid_ov", bus.out_valid, 0);
        check("mid_diff", bus.diff, 0);
        check("mid_bout", bus.bout, 0);
        check("mid_rdy", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick;
        run(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
